// File: rtl/counter_wrap_tracker.sv
// rtl/counter_wrap_tracker.sv - wrap/step monitor for an enable/reset counter
// Optional match pulse: define COUNTER_WRAP_TRACKER_MATCH_EN.
module counter_wrap_tracker #(
    parameter int DATA_W = 4,
    parameter int WRAP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     src_reset,
    input  logic [DATA_W-1:0]        data,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        match_val,
    output logic                     wrap_pulse,
    output logic [WRAP_W-1:0]        wrap_count,
    output logic                     wrap_ovf,
    output logic                     step_err,
    output logic [WRAP_W+DATA_W-1:0] ext_count,
    output logic                     match_pulse
);

    typedef enum logic [1:0] {EMPTY, TRACK, HALT} state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   prev_data;
    logic                prev_en;
    logic                prev_srst;
    logic [DATA_W-1:0]   exp_data;
    logic                step_ok;
    logic                wrap_event;
    logic                err_event;
    logic                match_event;
    logic                wrap_sat;
    logic [WRAP_W-1:0]   wrap_count_next;

    // What the counter should show now, given what it saw last edge
    always_comb begin
        exp_data = prev_data;
        if (prev_srst) begin
            exp_data = '0;
        end else if (prev_en) begin
            exp_data = prev_data + DATA_W'(1);
        end
    end

    assign step_ok  = (data == exp_data);
    assign wrap_sat = &wrap_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   state_next = TRACK;
                TRACK:   state_next = step_ok ? TRACK : HALT;
                HALT:    state_next = HALT;
                default: state_next = EMPTY;
            endcase
        end
    end

    // A wrap needs a legal, enabled 15->0 step; src_reset returns never count
    always_comb begin
        wrap_event  = 1'b0;
        err_event   = 1'b0;
        match_event = 1'b0;
        if (state == TRACK && !clear) begin
            err_event  = !step_ok;
            wrap_event = step_ok && prev_en && !prev_srst &&
                         (prev_data == {DATA_W{1'b1}}) && (data == '0);
`ifdef COUNTER_WRAP_TRACKER_MATCH_EN
            match_event = (data == match_val) && (data != prev_data);
`endif
        end
    end

`ifndef COUNTER_WRAP_TRACKER_MATCH_EN
    logic unused_match;
    assign unused_match = ^match_val;
`endif

    assign wrap_count_next = (wrap_event && !wrap_sat) ? wrap_count + WRAP_W'(1) : wrap_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_data   <= '0;
            prev_en     <= 1'b0;
            prev_srst   <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            wrap_ovf    <= 1'b0;
            step_err    <= 1'b0;
            ext_count   <= '0;
            match_pulse <= 1'b0;
        end else begin
            prev_data <= data;
            prev_en   <= enable;
            prev_srst <= src_reset;
            if (clear) begin
                wrap_pulse  <= 1'b0;
                wrap_count  <= '0;
                wrap_ovf    <= 1'b0;
                step_err    <= 1'b0;
                ext_count   <= {{WRAP_W{1'b0}}, data};
                match_pulse <= 1'b0;
            end else begin
                wrap_pulse  <= wrap_event;
                match_pulse <= match_event;
                wrap_count  <= wrap_count_next;
                if (err_event) begin
                    step_err <= 1'b1;
                end
                if (wrap_event && wrap_sat) begin
                    wrap_ovf <= 1'b1;
                end
                if (state != HALT) begin
                    ext_count <= {wrap_count_next, data};
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_wrap_tracker.sv
// tb/tb_counter_wrap_tracker.sv - directed self-checking bench for counter_wrap_tracker
module tb_counter_wrap_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        src_reset;
    logic [3:0]  data;
    logic        clear;
    logic [3:0]  match_val;

    logic        wrap_pulse, wrap_ovf, step_err, match_pulse;
    logic [7:0]  wrap_count;
    logic [11:0] ext_count;

    logic        wrap_pulse2, wrap_ovf2, step_err2, match_pulse2;
    logic [1:0]  wrap_count2;
    logic [5:0]  ext_count2;

    logic [3:0]  cnt;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    counter_wrap_tracker #(.DATA_W(4), .WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .src_reset(src_reset), .data(data),
        .clear(clear), .match_val(match_val), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
        .wrap_ovf(wrap_ovf), .step_err(step_err), .ext_count(ext_count), .match_pulse(match_pulse)
    );

    counter_wrap_tracker #(.DATA_W(4), .WRAP_W(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .src_reset(src_reset), .data(data),
        .clear(clear), .match_val(match_val), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2),
        .wrap_ovf(wrap_ovf2), .step_err(step_err2), .ext_count(ext_count2), .match_pulse(match_pulse2)
    );

    // One counter cycle: present the counter's current value and controls, then advance it
    task automatic cyc(input logic en, input logic srst);
        enable    = en;
        src_reset = srst;
        data      = cnt;
        @(posedge clk);
        #1;
        if (srst) cnt = 4'd0;
        else if (en) cnt = cnt + 4'd1;
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b0; src_reset = 1'b0; data = 4'd0; clear = 1'b0;
        match_val = 4'd9; cnt = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({wrap_pulse, wrap_count, wrap_ovf, step_err, ext_count, match_pulse} !== 23'd0)
            $display("FAIL reset_outputs got %h expected 0", {wrap_pulse, wrap_count, wrap_ovf, step_err, ext_count, match_pulse}); else passed++;
        total++; if ({wrap_count2, wrap_ovf2, step_err2, ext_count2} !== 10'd0)
            $display("FAIL reset_outputs_w2 got %h expected 0", {wrap_count2, wrap_ovf2, step_err2, ext_count2}); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_wrap;
        int np = 0;
        int pidx = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0);
            if (wrap_pulse) begin np++; pidx = i; end
        end
        total++; if (np !== 1) $display("FAIL wrap_pulse_count got %0d expected 1", np); else passed++;
        total++; if (pidx !== 16) $display("FAIL wrap_pulse_cycle got %0d expected 16", pidx); else passed++;
        total++; if (wrap_count !== 8'd1) $display("FAIL wrap_count_1 got %0d expected 1", wrap_count); else passed++;
        total++; if (step_err !== 1'b0) $display("FAIL step_err_1 got %b expected 0", step_err); else passed++;
        total++; if (ext_count !== 12'h013) $display("FAIL ext_count_1 got %h expected 013", ext_count); else passed++;
    endtask

    task automatic test_hold;
        int np = 0;
        repeat (3) cyc(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0);
            if (wrap_pulse) np++;
        end
        total++; if (np !== 0) $display("FAIL hold_pulses got %0d expected 0", np); else passed++;
        total++; if (step_err !== 1'b0) $display("FAIL hold_step_err got %b expected 0", step_err); else passed++;
        total++; if (ext_count !== 12'h017) $display("FAIL hold_ext_count got %h expected 017", ext_count); else passed++;
    endtask

    task automatic test_step_error;
        int np = 0;
        cyc(1'b1, 1'b1);
        repeat (4) cyc(1'b1, 1'b0);
        total++; if (step_err !== 1'b0) $display("FAIL pre_jump_step_err got %b expected 0", step_err); else passed++;
        cnt = 4'd5;
        cyc(1'b1, 1'b0);
        total++; if (step_err !== 1'b1) $display("FAIL jump_step_err got %b expected 1", step_err); else passed++;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0);
            if (wrap_pulse) np++;
        end
        total++; if (np !== 0) $display("FAIL halt_pulses got %0d expected 0", np); else passed++;
        total++; if (wrap_count !== 8'd1) $display("FAIL halt_wrap_count got %0d expected 1", wrap_count); else passed++;
        total++; if (step_err !== 1'b1) $display("FAIL halt_step_err got %b expected 1", step_err); else passed++;
    endtask

    task automatic test_clear;
        int np = 0;
        clear = 1'b1;
        cyc(1'b1, 1'b0);
        clear = 1'b0;
        total++; if (step_err !== 1'b0) $display("FAIL clear_step_err got %b expected 0", step_err); else passed++;
        total++; if (wrap_count !== 8'd0) $display("FAIL clear_wrap_count got %0d expected 0", wrap_count); else passed++;
        cnt = cnt + 4'd5;
        cyc(1'b1, 1'b0);
        total++; if (step_err !== 1'b0) $display("FAIL post_clear_unchecked got %b expected 0", step_err); else passed++;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0);
            if (wrap_pulse) np++;
        end
        total++; if (np !== 1) $display("FAIL resume_pulses got %0d expected 1", np); else passed++;
        total++; if (wrap_count !== 8'd1) $display("FAIL resume_wrap_count got %0d expected 1", wrap_count); else passed++;
    endtask

    task automatic test_src_reset;
        int np = 0;
        for (int i = 0; i < 16; i++) begin
            if (cnt != 4'd15) cyc(1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1);
        if (wrap_pulse) np++;
        cyc(1'b0, 1'b0);
        if (wrap_pulse) np++;
        cyc(1'b1, 1'b0);
        if (wrap_pulse) np++;
        total++; if (np !== 0) $display("FAIL srst_pulses got %0d expected 0", np); else passed++;
        total++; if (step_err !== 1'b0) $display("FAIL srst_step_err got %b expected 0", step_err); else passed++;
        total++; if (wrap_count !== 8'd1) $display("FAIL srst_wrap_count got %0d expected 1", wrap_count); else passed++;
    endtask

    task automatic test_saturate;
        int np1 = 0;
        int np2 = 0;
        int nm = 0;
        int nm_exp;
        logic ovf_at3 = 1'bx;
        clear = 1'b1;
        cyc(1'b1, 1'b0);
        clear = 1'b0;
        for (int i = 0; i < 65; i++) begin
            cyc(1'b1, 1'b0);
            if (wrap_pulse) np1++;
            if (match_pulse) nm++;
            if (wrap_pulse2) begin
                np2++;
                if (np2 == 3) ovf_at3 = wrap_ovf2;
            end
        end
`ifdef COUNTER_WRAP_TRACKER_MATCH_EN
        nm_exp = 4;
`else
        nm_exp = 0;
`endif
        total++; if (wrap_count2 !== 2'd3) $display("FAIL sat_wrap_count got %0d expected 3", wrap_count2); else passed++;
        total++; if (wrap_ovf2 !== 1'b1) $display("FAIL sat_wrap_ovf got %b expected 1", wrap_ovf2); else passed++;
        total++; if (ovf_at3 !== 1'b0) $display("FAIL sat_ovf_before_4th got %b expected 0", ovf_at3); else passed++;
        total++; if (np2 !== 4) $display("FAIL sat_pulses got %0d expected 4", np2); else passed++;
        total++; if (np1 !== 4 || wrap_count !== 8'd4 || wrap_ovf !== 1'b0)
            $display("FAIL wide_wraps got %0d/%0d/%b expected 4/4/0", np1, wrap_count, wrap_ovf); else passed++;
        total++; if (nm !== nm_exp) $display("FAIL match_pulses got %0d expected %0d", nm, nm_exp); else passed++;
    endtask

    task automatic test_async_reset;
        repeat (3) cyc(1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if ({wrap_pulse, wrap_count, wrap_ovf, step_err, ext_count} !== 22'd0)
            $display("FAIL async_reset got %h expected 0", {wrap_pulse, wrap_count, wrap_ovf, step_err, ext_count}); else passed++;
        total++; if ({wrap_count2, wrap_ovf2} !== 3'd0)
            $display("FAIL async_reset_w2 got %h expected 0", {wrap_count2, wrap_ovf2}); else passed++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cnt = 4'd6;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        total++; if (step_err !== 1'b0) $display("FAIL post_reset_unchecked got %b expected 0", step_err); else passed++;
        total++; if (ext_count !== 12'h007) $display("FAIL post_reset_ext got %h expected 007", ext_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_hold();
        test_step_error();
        test_clear();
        test_src_reset();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
